// File: rtl/ssd_display_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : ssd_display_scheduler
// Brief    : Round-robin time-sharing of a two-digit SSD among requesters,
//            with a fixed dwell per grant and a blank gap between requesters.
// Revision : 1.0
// ============================================================================
module ssd_display_scheduler #(
    parameter int par_num_req      = 4,
    parameter int par_dwell_cycles = 20000000,
    parameter int par_blank_cycles = 2000000
) (
    input  logic                           i_clk_20mhz,
    input  logic                           i_rst_20mhz,
    input  logic [par_num_req-1:0]         i_req,
    input  logic [8*par_num_req-1:0]       i_value,
    output logic [par_num_req-1:0]         o_grant,
    output logic [$clog2(par_num_req)-1:0] o_grant_idx,
    output logic [7:0]                     o_value,
    output logic                           o_blank,
    output logic                           o_dwell_done
);
    localparam int c_idx_w   = $clog2(par_num_req);
    localparam int c_cnt_max = (par_dwell_cycles > par_blank_cycles) ? par_dwell_cycles
                                                                     : par_blank_cycles;
    localparam int c_cnt_w   = $clog2(c_cnt_max);

    localparam logic [c_cnt_w-1:0] c_dwell_load = c_cnt_w'(par_dwell_cycles - 1);
    localparam logic [c_cnt_w-1:0] c_blank_load = c_cnt_w'(par_blank_cycles - 1);
    localparam logic [c_idx_w-1:0] c_last_rst   = c_idx_w'(par_num_req - 1);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_show  = 2'd1;
    localparam logic [1:0] c_st_blank = 2'd2;

    logic [1:0]             r_state, w_state_nxt;
    logic [par_num_req-1:0] r_grant, w_grant_nxt;
    logic [c_idx_w-1:0]     r_grant_idx, w_grant_idx_nxt;
    logic [c_idx_w-1:0]     r_last, w_last_nxt;
    logic [7:0]             r_value, w_value_nxt;
    logic                   r_blank, w_blank_nxt;
    logic [c_cnt_w-1:0]     r_cnt, w_cnt_nxt;

    logic                   w_any;
    logic                   w_found;
    logic [c_idx_w-1:0]     w_winner;
    logic                   w_hold;
    logic                   w_expire;
    logic                   w_enter_show;

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        w_any    = |i_req;
        w_found  = 1'b0;
        w_winner = '0;
        for (int i = 1; i <= par_num_req; i++) begin
            if (!w_found && i_req[(int'(r_last) + i) % par_num_req]) begin
                w_found  = 1'b1;
                w_winner = c_idx_w'((int'(r_last) + i) % par_num_req);
            end
        end
    end

    assign w_hold   = i_req[r_grant_idx];
    assign w_expire = (r_state == c_st_show) && w_hold && (r_cnt == '0);

    always_ff @(posedge i_clk_20mhz or posedge i_rst_20mhz) begin
        if (i_rst_20mhz) begin
            r_state     <= c_st_idle;
            r_grant     <= '0;
            r_grant_idx <= '0;
            r_last      <= c_last_rst;
            r_value     <= 8'h00;
            r_blank     <= 1'b1;
            r_cnt       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_grant     <= w_grant_nxt;
            r_grant_idx <= w_grant_idx_nxt;
            r_last      <= w_last_nxt;
            r_value     <= w_value_nxt;
            r_blank     <= w_blank_nxt;
            r_cnt       <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_any) w_state_nxt = c_st_show;
            end
            c_st_show: begin
                // A grantee that withdraws leaves at once; others never pre-empt.
                if (!w_hold)
                    w_state_nxt = w_any ? c_st_blank : c_st_idle;
                else if (r_cnt == '0 && w_winner != r_grant_idx)
                    w_state_nxt = c_st_blank;
            end
            c_st_blank: begin
                if (r_cnt == '0) w_state_nxt = w_any ? c_st_show : c_st_idle;
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    assign w_enter_show = (w_state_nxt == c_st_show) && (r_state != c_st_show);

    always_comb begin
        w_grant_nxt     = r_grant;
        w_grant_idx_nxt = r_grant_idx;
        w_last_nxt      = r_last;
        w_value_nxt     = r_value;
        w_blank_nxt     = r_blank;
        w_cnt_nxt       = r_cnt;
        o_dwell_done    = w_expire;

        if (r_state == c_st_show)
            w_value_nxt = i_value[{r_grant_idx, 3'b000} +: 8];

        if (w_enter_show) begin
            w_grant_nxt           = '0;
            w_grant_nxt[w_winner] = 1'b1;
            w_grant_idx_nxt       = w_winner;
            w_last_nxt            = w_winner;
            w_value_nxt           = i_value[{w_winner, 3'b000} +: 8];
            w_blank_nxt           = 1'b0;
            w_cnt_nxt             = c_dwell_load;
        end else if (w_state_nxt == c_st_show) begin
            w_cnt_nxt = w_expire ? c_dwell_load : r_cnt - 1'b1;
        end else if (w_state_nxt == c_st_blank) begin
            w_grant_nxt = '0;
            w_blank_nxt = 1'b1;
            w_cnt_nxt   = (r_state == c_st_blank) ? r_cnt - 1'b1 : c_blank_load;
        end else begin
            w_grant_nxt = '0;
            w_blank_nxt = 1'b1;
            w_cnt_nxt   = '0;
        end
    end

    assign o_grant     = r_grant;
    assign o_grant_idx = r_grant_idx;
    assign o_value     = r_value;
    assign o_blank     = r_blank;

endmodule
`default_nettype wire
